breath_key_ctrl: RTL and testbench

- Upstream control stage for the breathing-LED PWM block.
- Debounces one active-low push-button and classifies presses as short or long.
- Short press: cycles the breathing speed by selecting the duty-step size.
- Long press: toggles breathing enable.
- The new step size is handed to the PWM stage only at its duty-minimum sync point, so the duty ramp never lands off-grid.

---
 rtl/breath_key_ctrl_pkg.sv | 22 ++
 rtl/breath_key_ctrl_if.sv | 25 ++
 rtl/breath_key_ctrl_key_debounce.sv | 53 +++++
 rtl/breath_key_ctrl.sv | 132 +++++++++++++
 tb/tb_breath_key_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/breath_key_ctrl_pkg.sv
// Shared types and constants for the breathing-LED key control and PWM stages.
package breath_pkg;

  localparam int DUTY_W = 16;

  typedef logic [1:0] speed_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_t;

  // Duty step per PWM period for each speed; every entry divides the 5000-count
  // duty range so the ramp always returns exactly to zero.
  localparam logic [DUTY_W-1:0] STEP_TABLE [0:3] = '{16'd25, 16'd50, 16'd100, 16'd125};

  function automatic logic [DUTY_W-1:0] step_of(speed_idx_t idx);
    return STEP_TABLE[idx];
  endfunction

endpackage

// File: rtl/breath_key_ctrl_if.sv
// Key input, PWM sync and speed/enable outputs between key control and PWM stage.
interface breath_key_ctrl_if;
  import breath_pkg::*;

  logic              key_n;
  logic              pwm_sync;
  logic              breath_en;
  logic [DUTY_W-1:0] step_size;
  speed_idx_t        speed_idx;
  logic              short_pulse;
  logic              long_pulse;

  // Key control side: consumes the button and sync, produces speed/enable.
  modport master (
    input  key_n, pwm_sync,
    output breath_en, step_size, speed_idx, short_pulse, long_pulse
  );

  // PWM / board side: drives the button and sync, consumes speed/enable.
  modport slave (
    output key_n, pwm_sync,
    input  breath_en, step_size, speed_idx, short_pulse, long_pulse
  );

endinterface

// File: rtl/breath_key_ctrl_key_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debounce for an active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_key_lvl,
  output logic o_rel_ok
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [1:0]       r_sync_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_lvl;
  logic             w_key_s;

  assign w_key_s = r_sync[1];

  // Synchronise the raw key; the valid shift marks when r_sync holds real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync     <= {r_sync[0], i_key_n};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_key_lvl <= 1'b1;
    end else if (w_key_s == r_key_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt     <= '0;
      r_key_lvl <= w_key_s;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_key_lvl = r_key_lvl;
  // Key genuinely seen released: gates presses so a key held through reset is ignored.
  assign o_rel_ok  = r_sync_vld[1] & w_key_s & r_key_lvl;

endmodule

// File: rtl/breath_key_ctrl.sv
// Button press classification (short/long) and sync-aligned speed/enable control.
module breath_key_ctrl
  import breath_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  breath_key_ctrl_if.master   io_bus
);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic              w_key_lvl;
  logic              w_rel_ok;
  press_state_t      r_state;
  press_state_t      w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_armed;
  logic              r_short_pulse;
  logic              r_long_pulse;
  logic              w_short_nxt;
  logic              w_long_nxt;
  logic              r_breath_en;
  speed_idx_t        r_pend_idx;
  logic              r_pend_vld;
  speed_idx_t        r_speed_idx;
  logic [DUTY_W-1:0] r_step_size;
  speed_idx_t        w_pend_idx_eff;
  logic              w_pend_vld_eff;
  logic              w_apply;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_key_n  (io_bus.key_n),
    .o_key_lvl(w_key_lvl),
    .o_rel_ok (w_rel_ok)
  );

  // Press FSM state, hold counter, registered pulses and release arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_armed       <= 1'b0;
      r_short_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_armed       <= r_armed | w_rel_ok;
      r_short_pulse <= w_short_nxt;
      r_long_pulse  <= w_long_nxt;
    end
  end

  // Next state: a press starts on a debounced low; release or hold threshold ends it.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_key_lvl) begin
          w_state_nxt = ST_PRESSED;
          w_hold_nxt  = '0;
        end
      end
      ST_PRESSED: begin
        if (w_key_lvl) begin
          w_short_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = ST_LONG_HELD;
          w_hold_nxt  = r_hold_cnt + 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (w_key_lvl) begin
          w_state_nxt = ST_IDLE;
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A short pulse in the same cycle as the apply condition is folded in directly.
  assign w_pend_idx_eff = r_short_pulse ? speed_idx_t'(r_pend_idx + 2'd1) : r_pend_idx;
  assign w_pend_vld_eff = r_pend_vld | r_short_pulse;
  assign w_apply        = w_pend_vld_eff & (io_bus.pwm_sync | ~r_breath_en);

  // Enable toggle on long press; pending speed applied only at the duty-zero sync point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_breath_en <= 1'b1;
      r_pend_idx  <= '0;
      r_pend_vld  <= 1'b0;
      r_speed_idx <= '0;
      r_step_size <= step_of(2'd0);
    end else begin
      r_breath_en <= r_breath_en ^ w_long_nxt;
      r_pend_idx  <= w_pend_idx_eff;
      if (w_apply) begin
        r_speed_idx <= w_pend_idx_eff;
        r_step_size <= step_of(w_pend_idx_eff);
        r_pend_vld  <= 1'b0;
      end else begin
        r_pend_vld  <= w_pend_vld_eff;
      end
    end
  end

  assign io_bus.breath_en   = r_breath_en;
  assign io_bus.step_size   = r_step_size;
  assign io_bus.speed_idx   = r_speed_idx;
  assign io_bus.short_pulse = r_short_pulse;
  assign io_bus.long_pulse  = r_long_pulse;

endmodule

// File: tb/tb_breath_key_ctrl.sv
// Bench for breath_key_ctrl: scenario table, hand sequences and random key activity
// checked every cycle against a timestamp-based behavioural model.
module tb_breath_key_ctrl;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  breath_key_ctrl_if bus();

  breath_key_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_err = 0;
  int n_chk = 0;
  int n_short = 0;
  int n_long = 0;

  int STEP [0:3] = '{25, 50, 100, 125};

  // Behavioural model state
  bit samp[$];
  int since;
  bit m_lvl, m_prev_lvl, m_armed, m_act;
  int m_fall_t;
  bit m_en, m_pv, m_short, m_long;
  int m_idx, m_pidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'd0, bus.breath_en, bus.speed_idx, bus.step_size, bus.short_pulse, bus.long_pulse};
  endfunction

  function automatic logic [31:0] mk_vec(bit en, int idx, bit sp, bit lp);
    logic [1:0]  i2;
    logic [15:0] st;
    i2 = idx[1:0];
    st = STEP[idx][15:0];
    return {11'd0, en, i2, st, sp, lp};
  endfunction

  // One clock edge of the model, using the inputs sampled at that edge.
  // Debounced level: flips when the last D synchronised samples (key delayed two
  // edges) all disagree with it. A press starts at an armed falling edge E; it is
  // short if released by edge E+L, otherwise long at edge E+L+1.
  task automatic model_edge(input logic rst_l, input logic key, input logic sync);
    bit old_lvl, old_en, old_short, win, fell, eff_v;
    int eff_p;
    if (!rst_l) begin
      samp.delete();
      for (int j = 0; j < D + 2; j++) samp.push_back(1'b1);
      since = 0; m_lvl = 1; m_prev_lvl = 1; m_armed = 0; m_act = 0; m_fall_t = 0;
      m_en = 1; m_idx = 0; m_pidx = 0; m_pv = 0; m_short = 0; m_long = 0;
      return;
    end
    since++;
    samp.push_back(key);
    if (samp.size() > D + 3) void'(samp.pop_front());
    old_lvl = m_lvl; old_en = m_en; old_short = m_short;
    win = 1;
    for (int j = 2; j <= D + 1; j++)
      if (samp[samp.size() - 1 - j] == old_lvl) win = 0;
    m_short = 0; m_long = 0;
    fell = m_prev_lvl && !old_lvl;
    if (m_act) begin
      if (old_lvl) begin m_short = 1; m_act = 0; end
      else if (since == m_fall_t + L + 1) begin m_long = 1; m_act = 0; end
    end else if (fell && m_armed) begin
      m_act = 1; m_fall_t = since - 1;
    end
    m_en = old_en ^ m_long;
    eff_p = old_short ? (m_pidx + 1) % 4 : m_pidx;
    eff_v = m_pv | old_short;
    if (eff_v && (sync || !old_en)) begin m_idx = eff_p; m_pv = 0; end
    else m_pv = eff_v;
    m_pidx = eff_p;
    if (since >= 3 && samp[samp.size() - 3] == 1'b1 && old_lvl) m_armed = 1;
    m_prev_lvl = old_lvl;
    m_lvl = win ? !old_lvl : old_lvl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst_n, bus.key_n, bus.pwm_sync);
    #1;
    if (bus.short_pulse) n_short++;
    if (bus.long_pulse) n_long++;
    chk("model_cycle", dut_vec(), mk_vec(m_en, m_idx, m_short, m_long));
  endtask

  typedef struct {
    int hold;
    bit sync;
    int d_short;
    int d_long;
    bit en;
    int idx;
  } row_t;

  row_t tbl [10];

  initial begin
    int s0, l0, lvl, len;
    bit seen;
    tbl[0] = '{10, 0, 1, 0, 1, 0};  // short, pending, no sync yet
    tbl[1] = '{0,  1, 0, 0, 1, 1};  // sync applies speed 1
    tbl[2] = '{10, 0, 1, 0, 1, 1};  // short pending 2
    tbl[3] = '{30, 0, 0, 1, 0, 2};  // long: disable, pending applies at once
    tbl[4] = '{20, 0, 1, 0, 0, 3};  // longest short press, applies while disabled
    tbl[5] = '{4,  0, 1, 0, 0, 0};  // shortest accepted press, wrap 3->0
    tbl[6] = '{21, 0, 0, 1, 1, 0};  // shortest long press re-enables
    tbl[7] = '{3,  1, 0, 0, 1, 0};  // glitch ignored, sync with nothing pending
    tbl[8] = '{10, 0, 1, 0, 1, 0};  // short, pending 1
    tbl[9] = '{10, 1, 1, 0, 1, 2};  // second short then sync: single jump to 2

    bus.key_n = 1'b1;
    bus.pwm_sync = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_state", dut_vec(), mk_vec(1, 0, 0, 0));
    rst_n = 1'b1;
    repeat (5) tick();

    for (int r = 0; r < 10; r++) begin
      s0 = n_short; l0 = n_long;
      if (tbl[r].hold > 0) begin
        bus.key_n = 1'b0;
        repeat (tbl[r].hold) tick();
        bus.key_n = 1'b1;
      end
      repeat (D + 12) tick();
      if (tbl[r].sync) begin
        bus.pwm_sync = 1'b1; tick(); bus.pwm_sync = 1'b0;
      end
      repeat (3) tick();
      chk($sformatf("row%0d_short", r), n_short - s0, tbl[r].d_short);
      chk($sformatf("row%0d_long", r), n_long - l0, tbl[r].d_long);
      chk($sformatf("row%0d_en", r), bus.breath_en, tbl[r].en);
      chk($sformatf("row%0d_idx", r), bus.speed_idx, tbl[r].idx);
      chk($sformatf("row%0d_step", r), bus.step_size, STEP[tbl[r].idx]);
    end

    // Reset asserted mid-press, key kept held through reset release
    bus.key_n = 1'b0;
    repeat (22) tick();
    s0 = n_short; l0 = n_long;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", dut_vec(), mk_vec(1, 0, 0, 0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("held_thru_reset_short", n_short - s0, 0);
    chk("held_thru_reset_long", n_long - l0, 0);
    bus.key_n = 1'b1;
    repeat (D + 12) tick();
    bus.key_n = 1'b0;
    repeat (10) tick();
    bus.key_n = 1'b1;
    repeat (D + 12) tick();
    chk("repress_short", n_short - s0, 1);

    // short_pulse and pwm_sync in the same cycle
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    bus.key_n = 1'b0;
    repeat (10) tick();
    bus.key_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.short_pulse) seen = 1;
    end
    chk("short_seen", seen, 1);
    bus.pwm_sync = 1'b1; tick(); bus.pwm_sync = 1'b0;
    chk("same_cycle_idx", bus.speed_idx, 1);
    chk("same_cycle_step", bus.step_size, 50);
    repeat (3) tick();
    bus.pwm_sync = 1'b1; tick(); bus.pwm_sync = 1'b0;
    repeat (2) tick();
    chk("no_pending_idx", bus.speed_idx, 1);

    // Random key runs with glitches and random sync pulses
    for (int r = 0; r < 150; r++) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 35);
      for (int i = 0; i < len; i++) begin
        bus.key_n = lvl[0];
        bus.pwm_sync = ($urandom_range(0, 5) == 0);
        tick();
      end
    end
    bus.key_n = 1'b1;
    bus.pwm_sync = 1'b0;
    repeat (D + 12) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
